// File: rtl/fsm_share_arbiter.sv
// Round-robin arbiter that time-shares one fsm (a/b/c in, k/m/l out) between NUM_REQ requesters.
// Optional forced release after TIMEOUT grant cycles when FSM_ARB_TIMEOUT_EN is defined.

module fsm_share_lane (
  input  logic       gnt_i,
  input  logic       req_i,
  input  logic [2:0] abc_i,
  output logic       own_req_o,
  output logic [2:0] own_abc_o
);
  // Masking per lane keeps a non-owner from ever reaching the shared fsm.
  assign own_req_o = gnt_i & req_i;
  assign own_abc_o = gnt_i ? abc_i : 3'b000;
endmodule

module fsm_share_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int FLUSH_CYCLES = 1,
  parameter  int TIMEOUT      = 64,
  localparam int GID_W        = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_abc,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [GID_W-1:0]       grant_id,
  output logic                   busy,
  output logic                   fsm_a,
  output logic                   fsm_b,
  output logic                   fsm_c,
  input  logic                   fsm_k,
  input  logic                   fsm_m,
  input  logic                   fsm_l,
  output logic [2:0]             rsp_kml,
  output logic                   timeout
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_FLUSH} state_e;

  state_e                    state_q;
  logic [NUM_REQ-1:0]        gnt_q;
  logic [GID_W-1:0]          gid_q;
  logic [GID_W-1:0]          ptr_q;
  logic                      busy_q;
  logic [2:0]                abc_q;
  logic [3:0]                fcnt_q;

  logic [NUM_REQ-1:0]        lane_req;
  logic [NUM_REQ-1:0][2:0]   lane_abc;
  logic                      own_req;
  logic [2:0]                own_abc;
  logic                      win_found;
  logic [GID_W-1:0]          win_idx;
  logic [NUM_REQ-1:0]        win_oh;
  logic                      rel_go;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    fsm_share_lane u_lane (
      .gnt_i     (gnt_q[g]),
      .req_i     (req[g]),
      .abc_i     (req_abc[3*g +: 3]),
      .own_req_o (lane_req[g]),
      .own_abc_o (lane_abc[g])
    );
  end

  always_comb begin
    own_req = |lane_req;
    own_abc = 3'b000;
    for (int i = 0; i < NUM_REQ; i++) own_abc |= lane_abc[i];
  end

  // Search upward from ptr+1 so the last owner has the lowest priority.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = GID_W'(idx);
      end
    end
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
  end

`ifdef FSM_ARB_TIMEOUT_EN
  logic [15:0] tcnt_q;
  assign timeout = (state_q == S_GRANT) && own_req && (tcnt_q == 16'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  assign rel_go = (state_q == S_GRANT) && (!own_req || timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      gid_q   <= '0;
      ptr_q   <= GID_W'(NUM_REQ - 1);
      busy_q  <= 1'b0;
      abc_q   <= 3'b000;
      fcnt_q  <= 4'd0;
`ifdef FSM_ARB_TIMEOUT_EN
      tcnt_q  <= 16'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          abc_q <= 3'b000;
          if (win_found) begin
            gnt_q   <= win_oh;
            gid_q   <= win_idx;
            ptr_q   <= win_idx;
            busy_q  <= 1'b1;
            state_q <= S_GRANT;
`ifdef FSM_ARB_TIMEOUT_EN
            tcnt_q  <= 16'd0;
`endif
          end
        end
        S_GRANT: begin
          if (rel_go) begin
            gnt_q   <= '0;
            gid_q   <= '0;
            abc_q   <= 3'b000;
            fcnt_q  <= 4'(FLUSH_CYCLES - 1);
            state_q <= S_FLUSH;
          end else begin
            abc_q   <= own_abc;
`ifdef FSM_ARB_TIMEOUT_EN
            tcnt_q  <= tcnt_q + 16'd1;
`endif
          end
        end
        S_FLUSH: begin
          abc_q <= 3'b000;
          if (fcnt_q == 4'd0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            fcnt_q  <= fcnt_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign grant_id = gid_q;
  assign busy     = busy_q;
  assign {fsm_a, fsm_b, fsm_c} = abc_q;
  assign rsp_kml  = (|gnt_q) ? {fsm_k, fsm_m, fsm_l} : 3'b000;

endmodule

// File: tb/tb_fsm_share_arbiter.sv
// Directed bench for fsm_share_arbiter: grant-order scoreboard plus immediate-assert checks.
// A toy registered fsm (k=a&c, m=b, l=c) stands in for the shared fsm.

module tb_fsm_share_arbiter;

`ifdef FSM_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic clk, rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [3:0] gq[$];

  // DUT 1: FLUSH_CYCLES=1
  logic [3:0]  req, gnt;
  logic [11:0] abc;
  logic [1:0]  gid;
  logic        busy, fa, fb, fc, fk, fm, fl, to;
  logic [2:0]  kml;

  // DUT 2: FLUSH_CYCLES=3
  logic [3:0]  req2, gnt2;
  logic [11:0] abc2;
  logic [1:0]  gid2;
  logic        busy2, fa2, fb2, fc2, fk2, fm2, fl2, to2;
  logic [2:0]  kml2;

  fsm_share_arbiter #(.NUM_REQ(4), .FLUSH_CYCLES(1), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_abc(abc), .gnt(gnt), .grant_id(gid),
    .busy(busy), .fsm_a(fa), .fsm_b(fb), .fsm_c(fc), .fsm_k(fk), .fsm_m(fm), .fsm_l(fl),
    .rsp_kml(kml), .timeout(to));

  fsm_share_arbiter #(.NUM_REQ(4), .FLUSH_CYCLES(3), .TIMEOUT(TO)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .req_abc(abc2), .gnt(gnt2), .grant_id(gid2),
    .busy(busy2), .fsm_a(fa2), .fsm_b(fb2), .fsm_c(fc2), .fsm_k(fk2), .fsm_m(fm2), .fsm_l(fl2),
    .rsp_kml(kml2), .timeout(to2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {fk, fm, fl}    <= 3'b000;
      {fk2, fm2, fl2} <= 3'b000;
    end else begin
      {fk, fm, fl}    <= {fa & fc, fb, fc};
      {fk2, fm2, fl2} <= {fa2 & fc2, fb2, fc2};
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy !== 1'b0; i++) tick();
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Grant scoreboard: every 0 -> nonzero transition of gnt pops the next expected owner.
  logic [3:0] prev_gnt = 4'b0;
  always @(negedge clk) begin
    if (gnt !== 4'b0 && prev_gnt === 4'b0)
      chk("gnt_seq", 32'(gnt), (gq.size() > 0) ? 32'(gq.pop_front()) : 32'hffff_ffff);
    prev_gnt <= gnt;
  end

  initial begin
    int gap, w, g;
    logic abc_bad;
    logic [2:0] last_kml;
    rst_n = 1'b0; req = '0; abc = '0; req2 = '0; abc2 = '0;
    tick(); tick();
    // T1: reset values, async reset mid-grant, pointer reset
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_gid", 32'(gid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_abc", 32'({fa, fb, fc}), 0);
    chk("rst_to", 32'(to), 0);
    chk("rst_kml", 32'(kml), 0);
    rst_n = 1'b1;
    req = 4'b0001; abc[2:0] = 3'b101; gq.push_back(4'b0001);
    tick();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_abc_lat", 32'({fa, fb, fc}), 0);
    tick();
    chk("t1_abc", 32'({fa, fb, fc}), 32'b101);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_gnt", 32'(gnt), 0);
    chk("t1_async_abc", 32'({fa, fb, fc}), 0);
    chk("t1_async_busy", 32'(busy), 0);
    req = 4'b1111;
    tick();
    rst_n = 1'b1; gq.push_back(4'b0001);
    tick();
    chk("t1_regrant", 32'(gnt), 32'b0001);
    req = 4'b0000; abc = '0;
    wait_idle();

    // T2: single requester, 1-cycle abc latency, flush, rsp_kml
    req = 4'b0100; abc[8:6] = 3'b110; gq.push_back(4'b0100);
    tick();
    chk("t2_gid", 32'(gid), 2);
    chk("t2_abc0", 32'({fa, fb, fc}), 0);
    tick();
    chk("t2_abc1", 32'({fa, fb, fc}), 32'b110);
    tick();
    chk("t2_abc2", 32'({fa, fb, fc}), 32'b110);
    chk("t2_kml2", 32'(kml), 32'b010);
    tick();
    chk("t2_abc3", 32'({fa, fb, fc}), 32'b110);
    chk("t2_kml3", 32'(kml), 32'b010);
    req = 4'b0000;
    tick();
    chk("t2_rel_gnt", 32'(gnt), 0);
    chk("t2_rel_gid", 32'(gid), 0);
    chk("t2_rel_abc", 32'({fa, fb, fc}), 0);
    chk("t2_rel_busy", 32'(busy), 1);
    chk("t2_rel_kml", 32'(kml), 0);
    tick();
    chk("t2_idle_busy", 32'(busy), 0);
    abc = '0;

    // T3: round robin from reset pointer, 2-cycle re-grant gap
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 4'b1111;
    gq.push_back(4'b0001); gq.push_back(4'b0010); gq.push_back(4'b0100);
    gq.push_back(4'b1000); gq.push_back(4'b0001);
    for (int k = 0; k < 5; k++) begin
      gap = 0; g = 0;
      while (gnt === 4'b0 && g < 10) begin gap++; tick(); g++; end
      if (k > 0) chk("t3_gap", 32'(gap), 2);
      w = oh2i(gnt);
      tick();
      req[w] = 1'b0;
      tick();
      if (k < 4) req[w] = 1'b1;
    end
    req = 4'b0000;
    wait_idle();

    // T4: no pre-emption by a later requester
    req = 4'b0010; gq.push_back(4'b0010);
    tick();
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_hold", 32'(gnt), 32'b0010);
    end
    req = 4'b1000; gq.push_back(4'b1000);
    tick();
    chk("t4_rel", 32'(gnt), 0);
    tick();
    chk("t4_flush", 32'(gnt), 0);
    tick();
    chk("t4_next", 32'(gnt), 32'b1000);
    req = 4'b0000;
    wait_idle();

`ifdef FSM_ARB_TIMEOUT_EN
    // T6: forced release in grant cycle TIMEOUT, pending requester wins next
    req = 4'b0001; gq.push_back(4'b0001);
    tick();
    req = 4'b0011; gq.push_back(4'b0010);
    for (int c = 1; c <= 8; c++) begin
      chk("t6_to", 32'(to), (c == 8) ? 32'd1 : 32'd0);
      chk("t6_gnt", 32'(gnt), 32'b0001);
      if (c < 8) tick();
    end
    tick();
    chk("t6_to_off", 32'(to), 0);
    chk("t6_rel", 32'(gnt), 0);
    tick(); tick();
    chk("t6_next", 32'(gnt), 32'b0010);
`else
    // Without the timeout option a grant outlasts TIMEOUT cycles
    req = 4'b0001; gq.push_back(4'b0001);
    for (int c = 0; c < 70; c++) begin
      tick();
      chk("hold_to", 32'(to), 0);
    end
    chk("hold_gnt", 32'(gnt), 32'b0001);
`endif
    req = 4'b0000;
    wait_idle();

    // T5: FLUSH_CYCLES=3 gives three 000 cycles and an idle cycle before re-grant
    req2 = 4'b0001; abc2[2:0] = 3'b111; abc2[5:3] = 3'b010;
    tick();
    chk("t5_gnt", 32'(gnt2), 32'b0001);
    tick();
    chk("t5_abc", 32'({fa2, fb2, fc2}), 32'b111);
    tick();
    chk("t5_kml", 32'(kml2), 32'b111);
    req2 = 4'b0000;
    tick();
    chk("t5_rel_busy", 32'(busy2), 1);
    req2 = 4'b0010;
    gap = 0; g = 0; abc_bad = 1'b0; last_kml = 3'b111;
    while (gnt2 === 4'b0 && g < 12) begin
      gap++;
      if ({fa2, fb2, fc2} !== 3'b000) abc_bad = 1'b1;
      last_kml = {fk2, fm2, fl2};
      tick(); g++;
    end
    chk("t5_gap", 32'(gap), 4);
    chk("t5_abc_zero", 32'(abc_bad), 0);
    chk("t5_fsm_idle", 32'(last_kml), 0);
    chk("t5_next", 32'(gnt2), 32'b0010);
    req2 = 4'b0000;
    tick();

    chk("sb_empty", 32'(gq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
